// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: packet-atomic round-robin sharing of one UART TX byte stream, with a stall watchdog.
// Optional feature macro UART_TX_ARB_PRIO0_EN: requester 0 gets strict priority at every arbitration.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ          = 4,
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned TIMEOUT_CYCLES = 5000
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic [N_REQ-1:0]        req_valid,
    input  logic [N_REQ*DATA_W-1:0] req_data,
    input  logic [N_REQ-1:0]        req_last,
    output logic [N_REQ-1:0]        req_ready,
    output logic                    tx_valid,
    output logic [DATA_W-1:0]       tx_data,
    input  logic                    tx_ready,
    output logic [N_REQ-1:0]        grant,
    output logic                    busy,
    output logic                    timeout_pulse
);

    localparam int unsigned IDX_W = $clog2(N_REQ);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_TRIP = CNT_W'(TIMEOUT_CYCLES - 1);

`ifdef UART_TX_ARB_PRIO0_EN
    localparam bit PRIO0 = 1'b1;
`else
    localparam bit PRIO0 = 1'b0;
`endif

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  owner;
    logic [IDX_W-1:0]  owner_next;
    logic [IDX_W-1:0]  last_grant;
    logic [IDX_W-1:0]  last_grant_next;
    logic [N_REQ-1:0]  grant_next;
    logic [CNT_W-1:0]  wd_cnt;
    logic [CNT_W-1:0]  wd_cnt_next;
    logic              timeout_next;
    logic              tx_valid_next;
    logic [DATA_W-1:0] tx_data_next;

    logic              owner_valid;
    logic              owner_last;
    logic              owner_ready;
    logic [DATA_W-1:0] owner_data;
    logic              accept;

    logic              win_found;
    logic [IDX_W-1:0]  win_idx;

    // Scan starts just after the previous owner, so it naturally gets lowest priority.
    always_comb begin : arb_scan
        int unsigned cand;
        win_found = 1'b0;
        win_idx   = '0;
        cand      = 0;
        for (int unsigned i = 1; i <= N_REQ; i++) begin
            cand = 32'(last_grant) + i;
            if (cand >= N_REQ) begin
                cand = cand - N_REQ;
            end
            if (!win_found && req_valid[IDX_W'(cand)] && !(PRIO0 && (cand == 0))) begin
                win_found = 1'b1;
                win_idx   = IDX_W'(cand);
            end
        end
        if (PRIO0 && req_valid[0]) begin
            win_found = 1'b1;
            win_idx   = '0;
        end
    end

    always_comb begin
        owner_valid = req_valid[owner];
        owner_last  = req_last[owner];
        owner_data  = req_data[owner*DATA_W +: DATA_W];
        owner_ready = (state == S_GRANT) && (!tx_valid || tx_ready);
        accept      = owner_valid && owner_ready;
        req_ready   = '0;
        if (owner_ready) begin
            req_ready[owner] = 1'b1;
        end
    end

    always_comb begin
        state_next      = state;
        owner_next      = owner;
        last_grant_next = last_grant;
        grant_next      = grant;
        wd_cnt_next     = wd_cnt;
        timeout_next    = 1'b0;
        case (state)
            S_IDLE: begin
                wd_cnt_next = '0;
                if (win_found) begin
                    state_next          = S_GRANT;
                    owner_next          = win_idx;
                    grant_next          = '0;
                    grant_next[win_idx] = 1'b1;
                end
            end
            S_GRANT: begin
                if (accept) begin
                    wd_cnt_next = '0;
                    if (owner_last) begin
                        state_next      = S_IDLE;
                        last_grant_next = owner;
                        grant_next      = '0;
                    end
                end else if (!owner_valid) begin
                    // Only an absent source ages the watchdog; a blocked byte holds it.
                    if (wd_cnt >= CNT_TRIP) begin
                        state_next      = S_IDLE;
                        last_grant_next = owner;
                        grant_next      = '0;
                        timeout_next    = 1'b1;
                        wd_cnt_next     = CNT_SAT;
                    end else begin
                        wd_cnt_next = wd_cnt + 1'b1;
                    end
                end
            end
            default: begin
                state_next = S_IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_comb begin
        tx_valid_next = tx_valid;
        tx_data_next  = tx_data;
        if (accept) begin
            tx_valid_next = 1'b1;
            tx_data_next  = owner_data;
        end else if (tx_ready) begin
            tx_valid_next = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= S_IDLE;
            owner         <= '0;
            last_grant    <= LAST_IDX;
            grant         <= '0;
            wd_cnt        <= '0;
            timeout_pulse <= 1'b0;
            tx_valid      <= 1'b0;
            tx_data       <= '0;
        end else begin
            state         <= state_next;
            owner         <= owner_next;
            last_grant    <= last_grant_next;
            grant         <= grant_next;
            wd_cnt        <= wd_cnt_next;
            timeout_pulse <= timeout_next;
            tx_valid      <= tx_valid_next;
            tx_data       <= tx_data_next;
        end
    end

    assign busy = (state == S_GRANT) || tx_valid;

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares the single RS-232 UART transmit byte stream between N_REQ on-chip byte sources, for example posture-sample packets and test start/stop status reports.
- Arbitration is packet-atomic and round-robin. Once a requester is granted, it keeps the grant until the byte flagged last is accepted.
- A stall watchdog frees the link if the granted source stops delivering bytes.
- The output feeds the UART TX byte port through a single output register.

Parameters:
- N_REQ, 4, number of requesters; legal range 2..8.
- DATA_W, 8, byte width.
- TIMEOUT_CYCLES, 5000, number of consecutive idle cycles mid-packet before the grant is revoked; minimum 2.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- req_valid  in  N_REQ  per-requester byte valid.
- req_data  in  N_REQ*DATA_W  per-requester byte; requester i occupies bits [i*DATA_W +: DATA_W].
- req_last  in  N_REQ  marks the final byte of a packet.
- req_ready  out  N_REQ  per-requester byte accept.
- tx_valid  out  1  output byte valid.
- tx_data  out  DATA_W  output byte.
- tx_ready  in  1  UART accepts the byte.
- grant  out  N_REQ  one-hot current owner; zero when IDLE.
- busy  out  1  high in GRANT state or while tx_valid is high.
- timeout_pulse  out  1  one-cycle pulse when the watchdog revokes a grant.

Behaviour:
- Reset (async, reset_n=0):
  - req_ready, tx_valid, tx_data, grant, busy and timeout_pulse all go to 0.
  - last_grant resets to N_REQ-1, so the first arbitration favours requester 0.
  - Watchdog count resets to 0.
- State machine, two states:
  - IDLE -> GRANT when any req_valid bit is set.
  - Winner = first set req_valid bit scanning (last_grant+1) mod N_REQ upward with wrap-around.
  - grant is registered. No byte is accepted in the arbitration cycle, so first-byte latency is 1 cycle from req_valid to req_ready.
- GRANT, owner g:
  - req_ready[g] = ~tx_valid | tx_ready. All other req_ready bits are 0.
  - Accept = req_valid[g] & req_ready[g].
  - On accept, the output register loads req_data[g] and tx_valid is set.
- Output register:
  - tx_valid clears when tx_ready is high and no new byte is accepted in the same cycle.
  - Accept and drain in the same cycle reloads the register, sustaining 1 byte/cycle.
  - tx_data is held stable while tx_valid & ~tx_ready.
- Packet end: accepting a byte with req_last[g]=1 takes GRANT -> IDLE, sets last_grant=g and clears grant in the next cycle. The output register keeps draining independently.
- Re-arbitration: the minimum gap between packets is 1 IDLE cycle. In that cycle the just-finished requester has the lowest priority.
- Watchdog:
  - In GRANT the counter increments each cycle req_valid[g]=0 and clears to 0 on accept.
  - It holds, not incrementing, while req_valid[g]=1 and the byte is blocked by tx_ready=0. Backpressure is never a timeout.
  - On reaching TIMEOUT_CYCLES: GRANT -> IDLE, timeout_pulse=1 for one cycle, last_grant=g. Already-accepted bytes still drain.
  - Counter width is clog2(TIMEOUT_CYCLES+1). It saturates and never wraps.
- Invalid stimulus: req_last with req_valid low is ignored. req_valid from non-owners is held off (ready=0) with no loss.
- busy = (state==GRANT) | tx_valid.

Optional Feature:
- Macro: UART_TX_ARB_PRIO0_EN.
- When defined: requester 0 has strict priority at every IDLE arbitration. Round-robin applies among requesters 1..N_REQ-1 only. Packet atomicity is unchanged, so requester 0 never preempts an in-progress packet.
- When undefined: pure round-robin over all N_REQ.

Test Plan (N_REQ=4, TIMEOUT_CYCLES=16):
- Reset release, all requesters present 3-byte packets at once -> grant order 0,1,2,3. Each packet appears contiguously on tx_data, 1 IDLE cycle between packets.
- Requester 2 sends bytes 0x41,0x42,0x43(last) with tx_ready held 0 for 20 cycles after the first byte -> tx_data holds 0x41, no timeout_pulse, then 0x42,0x43 follow in order.
- Requester 1 sends 0x10, then drops req_valid -> after 16 idle cycles timeout_pulse=1 for 1 cycle, grant=0, next arbitration starts from requester 2.
- Requester 3 streams 8 bytes back-to-back with tx_ready=1 -> 8 consecutive tx_valid cycles, req_ready[3] continuously 1.
- reset_n asserted mid-packet with tx_valid=1 -> all outputs 0 immediately (async). After release, first grant goes to requester 0.
- With UART_TX_ARB_PRIO0_EN, requesters 0 and 3 repeatedly valid -> requester 0 wins every IDLE arbitration. Without the macro they alternate 0,3,0,3.
